// File: rtl/shift_add_controller_pkg.sv
// Shared definitions for the shift-add multiplier: controller state encoding and default width.
package shift_add_controller_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADD_CHK = 2'd1,
        S_SHIFT   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/shift_add_controller_step_counter.sv
// N-step shift counter; K flags that the shift in progress is the last one of the run.
module step_counter
    import shift_add_controller_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clr,
    input  logic Inc,
    output logic K
);

    localparam int CW = $clog2(N);

    logic [CW-1:0] count;

    // Clear beats increment so a Load always starts the run from zero.
    always_ff @(posedge Clk) begin
        if (Reset || Clr)
            count <= '0;
        else if (Inc)
            count <= count + CW'(1);
    end

    assign K = (count == CW'(N - 1));

endmodule

// File: rtl/shift_add_controller.sv
// Control FSM for the shift-add multiplier: sequences Load/Ad/Sh and owns the step counter.
module shift_add_controller
    import shift_add_controller_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic St,
    input  logic M,
    output logic Load,
    output logic Ad,
    output logic Sh,
    output logic Done,
    output logic Busy
);

    state_t state, state_nx;
    logic   k;
    logic   load_d, ad_d, sh_d;

    step_counter #(.N(N)) u_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr   (Load),
        .Inc   (Sh),
        .K     (k)
    );

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load_d   = 1'b0;
        ad_d     = 1'b0;
        sh_d     = 1'b0;
        case (state)
            S_IDLE: begin
                if (St) begin
                    load_d   = 1'b1;
                    state_nx = S_ADD_CHK;
                end
            end
            S_ADD_CHK: begin
                if (M) begin
                    ad_d     = 1'b1;
                    state_nx = S_SHIFT;
                end else begin
                    sh_d     = 1'b1;
                    state_nx = k ? S_DONE : S_ADD_CHK;
                end
            end
            S_SHIFT: begin
                sh_d     = 1'b1;
                state_nx = k ? S_DONE : S_ADD_CHK;
            end
            S_DONE: begin
                if (!St)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Strobes act on the datapath at the same edge as Reset, so Reset must mask them.
    assign Load = load_d && !Reset;
    assign Ad   = ad_d   && !Reset;
    assign Sh   = sh_d   && !Reset;
    assign Done = (state == S_DONE);
    assign Busy = (state == S_ADD_CHK) || (state == S_SHIFT);

endmodule

// File: tb/tb_shift_add_controller.sv
// Bench for shift_add_controller: a small datapath model drives M; runs are checked against a*b and bit-count timing.
module tb_shift_add_controller;

    localparam int N = 4;

    logic Clk = 1'b0;
    logic Reset, St, M;
    logic Load, Ad, Sh, Done, Busy;

    int tests_run = 0;
    int failures  = 0;

    logic [3:0] mcand, mplier;
    logic [8:0] acc = '0;
    logic [4:0] tr [0:63];   // {Load, Ad, Sh, Done, Busy} per cycle
    int         done_cyc;
    logic [7:0] prod;

    shift_add_controller #(.N(N)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .St    (St),
        .M     (M),
        .Load  (Load),
        .Ad    (Ad),
        .Sh    (Sh),
        .Done  (Done),
        .Busy  (Busy)
    );

    always #5 Clk = ~Clk;

    // Datapath: accumulator high half plus multiplier shift register in the low half.
    always @(posedge Clk) begin
        if (Load)
            acc <= {5'b0, mplier};
        else if (Ad)
            acc <= {({1'b0, acc[7:4]} + {1'b0, mcand}), acc[3:0]};
        else if (Sh)
            acc <= acc >> 1;
    end
    assign M = acc[0];

    always @(negedge Clk) begin
        if (!$isunknown({Load, Ad, Sh})) begin
            tests_run++;
            if ($countones({Load, Ad, Sh}) > 1) begin
                failures++;
                $display("FAIL onehot t=%0t strobes=%b required at most one high", $time, {Load, Ad, Sh});
            end
        end
    end

    // Drives one run and records outputs; entered and left at posedge+1.
    task automatic capture(input logic [3:0] a, input logic [3:0] b,
                           input logic [63:0] st_mask, input int rst_at, input int ncyc);
        mcand    = a;
        mplier   = b;
        done_cyc = -1;
        prod     = '0;
        for (int c = 0; c < ncyc; c++) begin
            St    = st_mask[c];
            Reset = (c == rst_at);
            @(negedge Clk);
            tr[c] = {Load, Ad, Sh, Done, Busy};
            if (Done && done_cyc < 0) begin
                done_cyc = c;
                prod     = acc[7:0];
            end
            @(posedge Clk); #1;
        end
        St    = 1'b0;
        Reset = 1'b0;
    endtask

    // Full-run check: strobe order from multiplier bits, Done cycle, product.
    task automatic test_run(input string name, input logic [3:0] a, input logic [3:0] b);
        logic [2:0] q[$];
        int exp_done;
        q.push_back(3'b100);
        for (int i = 0; i < N; i++) begin
            if (b[i]) q.push_back(3'b010);
            q.push_back(3'b001);
        end
        exp_done = 1 + N + $countones(b);
        capture(a, b, 64'd1, -1, exp_done + 3);
        for (int c = 0; c < q.size(); c++) begin
            tests_run++;
            if (tr[c][4:2] !== q[c]) begin
                failures++;
                $display("FAIL %s strobes c%0d got=%b exp=%b", name, c, tr[c][4:2], q[c]);
            end
            tests_run++;
            if (tr[c][0] !== (c >= 1)) begin
                failures++;
                $display("FAIL %s busy c%0d got=%b exp=%b", name, c, tr[c][0], (c >= 1));
            end
        end
        tests_run++;
        if (done_cyc != exp_done) begin
            failures++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc, exp_done);
        end
        tests_run++;
        if (prod !== 8'(a * b)) begin
            failures++;
            $display("FAIL %s product got=%0d exp=%0d", name, prod, a * b);
        end
        tests_run++;
        if (tr[exp_done + 1][1] !== 1'b0 || tr[exp_done + 2] !== 5'b0) begin
            failures++;
            $display("FAIL %s return_idle got=%b,%b exp Done=0 then all 0", name, tr[exp_done + 1], tr[exp_done + 2]);
        end
    endtask

    task automatic test_reset();
        St = 1'b0; Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        tests_run++;
        if ({Load, Ad, Sh, Done, Busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset outputs got=%b exp=00000", {Load, Ad, Sh, Done, Busy});
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_st_hold();
        // St high c0..c11 (pop(6)=2, Done at c7), released at c12.
        capture(4'd5, 4'd6, (64'd1 << 12) - 64'd1, -1, 15);
        for (int c = 7; c <= 12; c++) begin
            tests_run++;
            if (tr[c][1] !== 1'b1) begin
                failures++;
                $display("FAIL st_hold done_held c%0d got=%b exp=1", c, tr[c][1]);
            end
        end
        for (int c = 1; c < 15; c++) begin
            tests_run++;
            if (tr[c][4] !== 1'b0) begin
                failures++;
                $display("FAIL st_hold restart c%0d load got=%b exp=0", c, tr[c][4]);
            end
        end
        tests_run++;
        if (tr[13] !== 5'b0) begin
            failures++;
            $display("FAIL st_hold idle_after_release got=%b exp=00000", tr[13]);
        end
        test_run("st_hold_rerun", 4'd9, 4'd3);
    endtask

    task automatic test_reset_mid();
        capture(4'd15, 4'd15, 64'd1, 3, 8);
        tests_run++;
        if (tr[4] !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid c4 outputs got=%b exp=00000", tr[4]);
        end
        tests_run++;
        if (done_cyc != -1) begin
            failures++;
            $display("FAIL reset_mid spurious_done got=c%0d exp=none", done_cyc);
        end
        test_run("reset_mid_rerun", 4'd15, 4'd15);
    endtask

    task automatic test_st_busy_and_reset();
        logic [63:0] m;
        m = 64'd1;
        for (int c = 1; c <= 6; c++) m[c] = 1'($urandom_range(0, 1));
        capture(4'd7, 4'd10, m, -1, 10);
        for (int c = 1; c < 10; c++) begin
            tests_run++;
            if (tr[c][4] !== 1'b0) begin
                failures++;
                $display("FAIL st_busy extra_load c%0d got=%b exp=0", c, tr[c][4]);
            end
        end
        tests_run++;
        if (done_cyc != 7 || prod !== 8'd70) begin
            failures++;
            $display("FAIL st_busy result got=c%0d/%0d exp=c7/70", done_cyc, prod);
        end
        St = 1'b1; Reset = 1'b1;
        @(negedge Clk);
        tests_run++;
        if (Load !== 1'b0) begin
            failures++;
            $display("FAIL reset_vs_st load got=%b exp=0", Load);
        end
        @(posedge Clk); #1;
        St = 1'b0; Reset = 1'b0;
        @(negedge Clk);
        tests_run++;
        if ({Busy, Done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_vs_st after got busy,done=%b exp=00", {Busy, Done});
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            test_run("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    initial begin
        St = 1'b0; Reset = 1'b0; mcand = '0; mplier = '0;
        test_reset();
        test_run("zero", 4'd9, 4'b0000);
        test_run("ones", 4'd15, 4'b1111);
        test_run("b1011", 4'd13, 4'b1011);
        test_st_hold();
        test_reset_mid();
        test_st_busy_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
